// File: rtl/prince_nf_pkg.sv
// Shared definitions for the PRINCE nibble-flow (threshold-masked) round controller.
package prince_nf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FWD,
        ST_MID_S,
        ST_MID_SI,
        ST_INV,
        ST_DONE
    } state_t;

    localparam int NUM_FWD_ROUNDS  = 5;
    localparam int NUM_INV_ROUNDS  = 5;
    localparam int RC_LAST         = 11;
    localparam int SBOX_STAGES_DEF = 2;

endpackage

// File: rtl/prince_nf_stage_cnt.sv
// Stage counter for the shared S-box pipeline: one-hot stage enable plus last-stage flag.
module prince_nf_stage_cnt #(
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic [STAGES-1:0] stage_en,
    output logic              last
);

    localparam int CW = (STAGES > 1) ? $clog2(STAGES) : 1;

    logic [CW-1:0] cnt;

    assign last     = run && (cnt == CW'(STAGES - 1));
    assign stage_en = run ? (STAGES'(1) << cnt) : '0;

    // Counter rests at zero outside datapath states because every layer ends on a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prince_nf_ctrl.sv
// Round sequencer for a masked PRINCE core: FWD rounds, middle S/S^-1 layers, INV rounds.
module prince_nf_ctrl
    import prince_nf_pkg::*;
#(
    parameter int SBOX_STAGES = SBOX_STAGES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   sel_in,
    output logic [SBOX_STAGES-1:0] stage_en,
    output logic                   lin_en,
    output logic [3:0]             rc_idx,
    output logic                   mid_sel,
    output logic                   inv_sel
);

    state_t     state;
    logic [2:0] rnd;
    logic       run;
    logic       last;

    assign run = (state == ST_FWD) || (state == ST_MID_S) ||
                 (state == ST_MID_SI) || (state == ST_INV);

    prince_nf_stage_cnt #(
        .STAGES(SBOX_STAGES)
    ) u_stage_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .stage_en (stage_en),
        .last     (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            rnd   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    state <= ST_FWD;
                    rnd   <= 3'd1;
                end
                ST_FWD: begin
                    if (last) begin
                        if (rnd == 3'(NUM_FWD_ROUNDS)) begin
                            state <= ST_MID_S;
                            rnd   <= 3'd1;
                        end else begin
                            rnd <= rnd + 3'd1;
                        end
                    end
                end
                ST_MID_S: begin
                    if (last) state <= ST_MID_SI;
                end
                ST_MID_SI: begin
                    if (last) begin
                        state <= ST_INV;
                        rnd   <= 3'd1;
                    end
                end
                ST_INV: begin
                    if (last) begin
                        if (rnd == 3'(NUM_INV_ROUNDS)) begin
                            state <= ST_DONE;
                            rnd   <= '0;
                        end else begin
                            rnd <= rnd + 3'd1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    rnd   <= '0;
                end
            endcase
        end
    end

    // All outputs decode from registered state only; start never reaches an output.
    assign busy    = (state == ST_LOAD) || run;
    assign done    = (state == ST_DONE);
    assign sel_in  = (state == ST_LOAD);
    assign lin_en  = last;
    assign mid_sel = (state == ST_MID_S);
    assign inv_sel = (state == ST_MID_SI) || (state == ST_INV);

    // The final inverse round folds RC11 and output whitening into one commit.
    always_comb begin
        rc_idx = 4'd0;
        if (state == ST_FWD) begin
            rc_idx = {1'b0, rnd};
        end else if (state == ST_INV) begin
            if (rnd == 3'(NUM_INV_ROUNDS)) rc_idx = 4'(RC_LAST);
            else                           rc_idx = {1'b0, rnd} + 4'(NUM_FWD_ROUNDS);
        end
    end

endmodule

// File: tb/tb_prince_nf_ctrl.sv
// Directed bench for prince_nf_ctrl at SBOX_STAGES = 1, 2 and 4.
module tb_prince_nf_ctrl;

    typedef struct {
        int         cyc;
        logic       busy;
        logic       sel_in;
        logic       done;
        logic       mid_sel;
        logic       inv_sel;
        logic       lin_en;
        logic [3:0] stage_en;
        logic [3:0] rc_idx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  start_v;
    logic [2:0]  busy_v, done_v, sel_v, lin_v, mid_v, inv_v;
    logic [11:0] rc_all;
    logic [0:0]  se1;
    logic [1:0]  se2;
    logic [3:0]  se4;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] exp_q[$];
    int   rc_seq [12] = '{1, 2, 3, 4, 5, 0, 0, 6, 7, 8, 9, 11};
    vec_t snaps [64];
    vec_t tbl   [15];

    always #5 clk = ~clk;

    prince_nf_ctrl #(.SBOX_STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .sel_in(sel_v[0]), .stage_en(se1), .lin_en(lin_v[0]), .rc_idx(rc_all[3:0]),
        .mid_sel(mid_v[0]), .inv_sel(inv_v[0])
    );

    prince_nf_ctrl u_s2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .sel_in(sel_v[1]), .stage_en(se2), .lin_en(lin_v[1]), .rc_idx(rc_all[7:4]),
        .mid_sel(mid_v[1]), .inv_sel(inv_v[1])
    );

    prince_nf_ctrl #(.SBOX_STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .sel_in(sel_v[2]), .stage_en(se4), .lin_en(lin_v[2]), .rc_idx(rc_all[11:8]),
        .mid_sel(mid_v[2]), .inv_sel(inv_v[2])
    );

    function automatic logic [3:0] get_se(input int k);
        case (k)
            0:       return {3'b000, se1};
            1:       return {2'b00, se2};
            default: return se4;
        endcase
    endfunction

    function automatic logic [3:0] get_rc(input int k);
        return rc_all[k*4 +: 4];
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_all_zero(input int k, input string tag);
        chk({tag, "_busy"},  k, busy_v[k], 0);
        chk({tag, "_done"},  k, done_v[k], 0);
        chk({tag, "_sel"},   k, sel_v[k],  0);
        chk({tag, "_lin"},   k, lin_v[k],  0);
        chk({tag, "_mid"},   k, mid_v[k],  0);
        chk({tag, "_inv"},   k, inv_v[k],  0);
        chk({tag, "_se"},    k, get_se(k), 0);
        chk({tag, "_rc"},    k, get_rc(k), 0);
    endtask

    // Start one encryption on instance k and compare every cycle against the
    // timeline implied by S stages per layer; optional ignored start pulses at 5 and 17.
    task automatic check_run(input int k, input int s, input int ncyc, input bit pulses);
        int   ph;
        bit   dp;
        logic [3:0] e_se;
        exp_q.delete();
        foreach (rc_seq[i]) exp_q.push_back(4'(rc_seq[i]));
        @(negedge clk);
        start_v[k] = 1'b1;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            @(posedge clk);
            #1;
            start_v[k] = pulses && (cyc == 5 || cyc == 17);
            dp   = (cyc >= 2) && (cyc <= 1 + 12*s);
            ph   = dp ? (cyc - 2) % s : 0;
            e_se = dp ? 4'(1 << ph) : 4'd0;
            chk("busy",     cyc, busy_v[k], (cyc >= 1 && cyc <= 1 + 12*s));
            chk("sel_in",   cyc, sel_v[k],  (cyc == 1));
            chk("done",     cyc, done_v[k], (cyc == 2 + 12*s));
            chk("mid_sel",  cyc, mid_v[k],  (cyc >= 2 + 5*s && cyc <= 1 + 6*s));
            chk("inv_sel",  cyc, inv_v[k],  (cyc >= 2 + 6*s && cyc <= 1 + 12*s));
            chk("stage_en", cyc, get_se(k), e_se);
            chk("lin_en",   cyc, lin_v[k],  (dp && ph == s - 1));
            if (lin_v[k] === 1'b1) begin
                if (exp_q.size() > 0) chk("rc_on_lin", cyc, get_rc(k), exp_q.pop_front());
                else                  chk("rc_extra_lin", cyc, 1, 0);
            end
            if (k == 1 && cyc < 64) begin
                snaps[cyc] = '{cyc, busy_v[k], sel_v[k], done_v[k], mid_v[k], inv_v[k],
                               lin_v[k], get_se(k), get_rc(k)};
            end
        end
        chk("rc_queue_left", ncyc, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cyc[$];
        int exp_done[3] = '{26, 53, 80};

        tbl[0]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[1]  = '{2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1};
        tbl[2]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1};
        tbl[3]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd5};
        tbl[4]  = '{11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5};
        tbl[5]  = '{12, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0};
        tbl[6]  = '{13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 4'd0};
        tbl[7]  = '{14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd0};
        tbl[8]  = '{15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd0};
        tbl[9]  = '{16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd6};
        tbl[10] = '{23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd9};
        tbl[11] = '{24, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd11};
        tbl[12] = '{25, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 4'd11};
        tbl[13] = '{26, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[14] = '{27, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

        // Clock/reset
        rst_n   = 1'b0;
        start_v = 3'b000;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) chk_all_zero(k, "reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default depth: full per-cycle check, then the hand-computed table.
        check_run(1, 2, 28, 1'b0);
        foreach (tbl[i]) begin
            chk("tbl_busy",  tbl[i].cyc, snaps[tbl[i].cyc].busy,     tbl[i].busy);
            chk("tbl_sel",   tbl[i].cyc, snaps[tbl[i].cyc].sel_in,   tbl[i].sel_in);
            chk("tbl_done",  tbl[i].cyc, snaps[tbl[i].cyc].done,     tbl[i].done);
            chk("tbl_mid",   tbl[i].cyc, snaps[tbl[i].cyc].mid_sel,  tbl[i].mid_sel);
            chk("tbl_inv",   tbl[i].cyc, snaps[tbl[i].cyc].inv_sel,  tbl[i].inv_sel);
            chk("tbl_lin",   tbl[i].cyc, snaps[tbl[i].cyc].lin_en,   tbl[i].lin_en);
            chk("tbl_se",    tbl[i].cyc, snaps[tbl[i].cyc].stage_en, tbl[i].stage_en);
            chk("tbl_rc",    tbl[i].cyc, snaps[tbl[i].cyc].rc_idx,   tbl[i].rc_idx);
        end

        // Start pulses while busy are ignored.
        check_run(1, 2, 30, 1'b1);

        // Other pipeline depths.
        check_run(0, 1, 16, 1'b0);
        check_run(2, 4, 52, 1'b0);

        // start held high: back-to-back runs, one IDLE cycle between them.
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int cyc = 1; cyc <= 85; cyc++) begin
            @(posedge clk);
            #1;
            if (done_v[1] === 1'b1) done_cyc.push_back(cyc);
            if (cyc == 80) start_v[1] = 1'b0;
        end
        chk("b2b_done_count", 85, done_cyc.size(), 3);
        foreach (exp_done[i]) begin
            if (i < done_cyc.size()) chk("b2b_done_cycle", exp_done[i], done_cyc[i], exp_done[i]);
            else                     chk("b2b_done_missing", exp_done[i], 0, 1);
        end
        chk("b2b_idle_busy", 85, busy_v[1], 0);

        // Asynchronous reset in cycle 10 aborts without done; next run is normal.
        @(negedge clk);
        start_v[1] = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk);
            #1;
            start_v[1] = 1'b0;
        end
        chk("pre_abort_busy", 10, busy_v[1], 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero(1, "abort");
        for (int cyc = 11; cyc <= 14; cyc++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", cyc, done_v[1], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_run(1, 2, 28, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prince_nf_ctrl.md
PRINCE_NF_CTRL -- requirements
Module: prince_nf_ctrl

Interface
REQ-001 Parameter SBOX_STAGES, default 2, meaning register stages per shared S-box layer (component-function chain); legal range 1..4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 start  in  1  request one encryption; sampled only in IDLE.
REQ-005 busy  out  1  high from LOAD through the last INV cycle.
REQ-006 done  out  1  one-cycle pulse; ciphertext shares valid in that cycle.
REQ-007 sel_in  out  1  high selects plaintext/key shares into the state register (LOAD only).
REQ-008 stage_en  out  SBOX_STAGES  one-hot enable of the S-box pipeline register currently being written.
REQ-009 lin_en  out  1  high on the last stage cycle of each S-box layer: commits linear layer, RC and key addition.
REQ-010 rc_idx  out  4  round-constant index, 0..11.
REQ-011 mid_sel  out  1  high selects M' (no ShiftRows) as linear layer.
REQ-012 inv_sel  out  1  high selects inverse S-box component functions and inverse linear layer.

Function
REQ-013 FSM states: IDLE, LOAD, FWD, MID_S, MID_SI, INV, DONE.
REQ-014 IDLE: all outputs 0; start=1 -> LOAD next cycle; start=0 -> stay.
REQ-015 LOAD: one cycle; sel_in=1, rc_idx=0 (whitening k0^k1^RC0); -> FWD.
REQ-016 A stage counter runs 0..SBOX_STAGES-1 in FWD, MID_S, MID_SI and INV; stage_en = one-hot(counter); lin_en=1 when counter = SBOX_STAGES-1; counter wraps to 0 on that cycle.
REQ-017 FWD: 5 rounds; round counter r = 1..5, rc_idx=r; after round 5 commits -> MID_S.
REQ-018 MID_S: one S-box layer with mid_sel=1, inv_sel=0, rc_idx=0 (no RC); -> MID_SI.
REQ-019 MID_SI: one S-box layer with inv_sel=1, mid_sel=0, rc_idx=0; -> INV.
REQ-020 INV: 5 rounds, inv_sel=1, rc_idx = 6..10; round 10 commit also applies RC11 and final whitening, rc_idx=11 in that round; -> DONE.
REQ-021 DONE: one cycle, done=1, busy=0; -> IDLE unconditionally (start in DONE ignored).
REQ-022 Latency: start sampled at edge 0 -> done high in cycle 2+12*SBOX_STAGES (26 for default).
REQ-023 start while busy or in DONE is ignored; no queuing.
REQ-024 Exactly one of stage_en bits is high in datapath states; stage_en=0 in IDLE, LOAD, DONE.
REQ-025 Outputs are registered or decoded only from registered state; no combinational path from start to any output.

Reset
REQ-026 rst_n low -> state IDLE, counters 0, all outputs 0, immediately (asynchronous), including mid-encryption.
REQ-027 After rst_n deasserts, first start is accepted on the next rising edge; aborted operation produces no done.

Structure
REQ-028 Shared package prince_nf_pkg holds: FSM state enum, NUM_FWD_ROUNDS=5, NUM_INV_ROUNDS=5, RC_LAST=11, default SBOX_STAGES.
REQ-029 One sub-module prince_nf_stage_cnt (stage counter with one-hot decode and last flag), instantiated once.
REQ-030 Controller contains no share data; it touches no masked values and introduces no randomness.

Verification
REQ-031 Reset, start=1 one cycle, SBOX_STAGES=2 -> sel_in high cycle 1, done high exactly cycle 26, busy high cycles 1..25.
REQ-032 Same run -> rc_idx sequence on lin_en cycles: 1,2,3,4,5,0,0,6,7,8,9,11; mid_sel high only cycles 12-13, inv_sel high cycles 14-25.
REQ-033 start held high continuously -> back-to-back encryptions, each done 27 cycles apart (DONE+IDLE gap), no extra starts.
REQ-034 rst_n pulled low in cycle 10 of an encryption -> outputs 0 same cycle; no done; new start after release completes normally in 26 cycles.
REQ-035 SBOX_STAGES=1 and 4 -> done at cycles 14 and 50; stage_en one-hot each datapath cycle, lin_en every 1 / 4 cycles.
REQ-036 start pulses while busy (cycles 5, 17) -> ignored; single done at cycle 26.
